// File: rtl/alu_operand_stage.sv
// alu_operand_stage
//   Registered operand/opcode stage feeding the 4-input ALU result mux.
//   Takes a command (A, B, op) over valid/ready, registers the four candidate
//   results (add, sub, and, or) plus the select, and holds them until the
//   consumer retires them. The mux output y is fed back into an accumulator
//   so chained commands can use the previous result as operand A.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   clear               sync clear of acc, op_count, out_valid
//   in_valid/in_ready   command handshake (in_ready = !out_valid || out_ready)
//   in_a, in_b, in_op   operands and op (0 add, 1 sub, 2 and, 3 or)
//   in_use_acc          take A from the accumulator (or y_fb on a same-cycle retire)
//   y_fb                mux result returned for accumulation
//   i0..i3, s           registered candidates and mux select
//   out_valid/out_ready result handshake
//   carry, borrow       flags of A+B and A-B
//   acc, op_count       accumulator and retired-operation counter
module alu_operand_stage #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_use_acc,
   input  logic [WIDTH-1:0] y_fb,
   output logic [WIDTH-1:0] i0,
   output logic [WIDTH-1:0] i1,
   output logic [WIDTH-1:0] i2,
   output logic [WIDTH-1:0] i3,
   output logic [1:0]       s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             carry,
   output logic             borrow,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);

   logic             accept;
   logic             retire;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign retire   = out_valid && out_ready;

   // On a back-to-back chain the result being retired this edge has not
   // reached acc yet, so take it straight from the mux feedback.
   always_comb begin
      op_a = in_a;
      if (in_use_acc) op_a = retire ? y_fb : acc;
   end

   // One extra bit: sum MSB is the carry, diff MSB is set exactly when A<B.
   assign sum  = {1'b0, op_a} + {1'b0, in_b};
   assign diff = {1'b0, op_a} - {1'b0, in_b};

   // Candidate/flag registers: only load on accept, which can only happen
   // when empty or retiring, so they are frozen while the consumer stalls.
   // clear does not touch them; out_valid going low is enough.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i0     <= '0;
         i1     <= '0;
         i2     <= '0;
         i3     <= '0;
         s      <= '0;
         carry  <= 1'b0;
         borrow <= 1'b0;
      end else if (accept && !clear) begin
         i0     <= sum[WIDTH-1:0];
         i1     <= diff[WIDTH-1:0];
         i2     <= op_a & in_b;
         i3     <= op_a | in_b;
         s      <= in_op;
         carry  <= sum[WIDTH];
         borrow <= diff[WIDTH];
      end
   end

   // Control: out_valid is the whole EMPTY/FULL state; clear wins over
   // accept and retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         acc       <= '0;
         op_count  <= '0;
      end else if (clear) begin
         out_valid <= 1'b0;
         acc       <= '0;
         op_count  <= '0;
      end else begin
         out_valid <= accept || (out_valid && !retire);
         if (retire) begin
            acc      <= y_fb;
            op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: a reference model tracks acc/op_count/valid,
// and expected candidate sets are queued on accept and compared against the
// DUT outputs every cycle they are presented, popped on retire.
module tb_alu_operand_stage;
   localparam int W = 4;
   localparam int C = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear, in_valid, in_ready, in_use_acc, out_valid, out_ready;
   logic [W-1:0] in_a, in_b, y_fb, i0, i1, i2, i3, acc;
   logic [1:0]   in_op, s;
   logic         carry, borrow;
   logic [C-1:0] op_count;

   always #5 clk = ~clk;

   alu_operand_stage #(.WIDTH(W), .CNT_W(C)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_use_acc(in_use_acc),
      .y_fb(y_fb),
      .i0(i0), .i1(i1), .i2(i2), .i3(i3), .s(s),
      .out_valid(out_valid), .out_ready(out_ready),
      .carry(carry), .borrow(borrow),
      .acc(acc), .op_count(op_count)
   );

   typedef struct packed {
      logic [W-1:0] r0, r1, r2, r3;
      logic [1:0]   sel;
      logic         c, b;
   } res_t;

   res_t         q[$];
   logic         m_valid;
   logic [W-1:0] m_acc;
   logic [C-1:0] m_cnt;
   int           checks = 0;
   int           errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
      res_t r;
      int   sm;
      sm    = int'(a) + int'(b);
      r.r0  = W'(sm % (1 << W));
      r.c   = (sm >= (1 << W));
      r.r1  = W'((int'(a) - int'(b) + (1 << W)) % (1 << W));
      r.b   = (a < b);
      r.r2  = a & b;
      r.r3  = a | b;
      r.sel = op;
      return r;
   endfunction

   task automatic chk_out(input res_t e);
      chk("i0", i0, e.r0);
      chk("i1", i1, e.r1);
      chk("i2", i2, e.r2);
      chk("i3", i3, e.r3);
      chk("s", s, e.sel);
      chk("carry", carry, e.c);
      chk("borrow", borrow, e.b);
   endtask

   // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
   task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic ua, input logic ordy,
                      input logic [W-1:0] yfb, input logic clr);
      logic         ret, acpt;
      logic [W-1:0] av;
      in_valid = v; in_a = a; in_b = b; in_op = op; in_use_acc = ua;
      out_ready = ordy; y_fb = yfb; clear = clr;
      #1;
      chk("in_ready", in_ready, !m_valid || ordy);
      if (m_valid && q.size() > 0) chk_out(q[0]);
      ret  = m_valid && ordy;
      acpt = v && (!m_valid || ordy);
      av   = ua ? (ret ? yfb : m_acc) : a;
      if (clr) begin
         m_acc = '0; m_cnt = '0; m_valid = 1'b0; q.delete();
      end else begin
         if (ret) begin
            m_acc = yfb; m_cnt = m_cnt + 1'b1;
            if (q.size() > 0) void'(q.pop_front());
         end
         if (acpt) q.push_back(model(av, b, op));
         m_valid = acpt || (m_valid && !ret);
      end
      @(posedge clk); #1;
      chk("out_valid", out_valid, m_valid);
      chk("acc", acc, m_acc);
      chk("op_count", op_count, m_cnt);
   endtask

   task automatic drain();
      cyc(1'b0, '0, '0, 2'd0, 1'b0, 1'b1, W'($urandom), 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      in_op = '0; in_use_acc = 1'b0; y_fb = '0; out_ready = 1'b0;
      m_valid = 1'b0; m_acc = '0; m_cnt = '0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_i0", i0, 0); chk("rst_i3", i3, 0);
      chk("rst_acc", acc, 0); chk("rst_cnt", op_count, 0);
      chk("rst_carry", carry, 0); chk("rst_borrow", borrow, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single add 9+8
      cyc(1, 4'd9, 4'd8, 2'd0, 0, 0, 0, 0);
      chk("add_valid", out_valid, 1); chk("add_i0", i0, 1); chk("add_carry", carry, 1);
      chk("add_i1", i1, 1); chk("add_borrow", borrow, 0);
      chk("add_i2", i2, 8); chk("add_i3", i3, 9); chk("add_s", s, 0);

      // retire the add, accept sub 3-5 in the same edge
      cyc(1, 4'd3, 4'd5, 2'd1, 0, 1, 4'd1, 0);
      chk("sub_i1", i1, 14); chk("sub_borrow", borrow, 1); chk("sub_s", s, 1);
      cyc(0, 0, 0, 0, 0, 1, 4'd14, 0);
      chk("sub_acc", acc, 14);

      // backpressure: hold 3 cycles with a pending command, then swap in one edge
      cyc(1, 4'd7, 4'd2, 2'd2, 0, 0, 0, 0);
      for (int k = 0; k < 3; k++) cyc(1, 4'd1, 4'd1, 2'd0, 0, 0, 0, 0);
      chk("bp_hold_s", s, 2);
      cyc(1, 4'd1, 4'd1, 2'd3, 0, 1, 4'd2, 0);
      chk("bp_swap_valid", out_valid, 1); chk("bp_swap_s", s, 3);
      drain();

      // back-to-back chain through the y_fb bypass
      cyc(1, 4'd2, 4'd3, 2'd0, 0, 0, 0, 0);
      cyc(1, 4'd0, 4'd1, 2'd0, 1, 1, 4'd5, 0);
      chk("chain_i0", i0, 6);
      drain();

      // random traffic
      for (int k = 0; k < 60; k++)
         cyc(1'($urandom), W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
             1'($urandom), W'($urandom), 1'($urandom_range(0, 15) == 0));
      drain();

      // counter wrap: 256 retires after a clear
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < 256; k++)
         cyc(1, W'($urandom), W'($urandom), 2'($urandom), 1'($urandom), 1, W'($urandom), 0);
      drain();
      chk("wrap_cnt", op_count, 0);

      // clear with acc=7, racing an accept and a retire
      cyc(1, 4'd4, 4'd3, 2'd0, 0, 0, 0, 0);
      cyc(1, 4'd1, 4'd1, 2'd0, 0, 1, 4'd7, 0);
      chk("pre_clr_acc", acc, 7);
      cyc(1, 4'd5, 4'd5, 2'd1, 0, 1, 4'd9, 1);
      chk("clr_acc", acc, 0); chk("clr_cnt", op_count, 0); chk("clr_valid", out_valid, 0);
      drain();

      // async reset while holding a result
      cyc(1, 4'd5, 4'd6, 2'd3, 0, 0, 0, 0);
      chk("hold_valid", out_valid, 1);
      out_ready = 1'b0; in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0); chk("arst_i0", i0, 0); chk("arst_i3", i3, 0);
      chk("arst_s", s, 0); chk("arst_acc", acc, 0); chk("arst_cnt", op_count, 0);
      rst_n = 1'b1;
      m_valid = 1'b0; m_acc = '0; m_cnt = '0; q.delete();
      @(posedge clk); #1;
      cyc(1, 4'd15, 4'd1, 2'd0, 0, 0, 0, 0);
      chk("post_arst_carry", carry, 1);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
